// File: rtl/soc_pkg.sv
// soc_pkg: shared encodings for the data-side memory unit.
//   - mem_size encodings (SIZE_WORD / SIZE_HALF / SIZE_BYTE; 2'b11 behaves as word)
//   - MMIO timer register byte offsets and CTRL bit indices
//   - sign-extension helpers used by the load path
package soc_pkg;

  typedef enum logic [1:0] {
    SIZE_WORD     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_BYTE     = 2'b10,
    SIZE_WORD_ALT = 2'b11
  } mem_size_e;

  localparam logic [3:0] OFF_COUNT  = 4'h0;
  localparam logic [3:0] OFF_CMP    = 4'h4;
  localparam logic [3:0] OFF_CTRL   = 4'h8;
  localparam logic [3:0] OFF_STATUS = 4'hC;

  localparam int CTRL_EN          = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    return {{16{h[15]}}, h};
  endfunction

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: 32-bit memory-mapped timer with compare match and interrupt.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   i_we         : aligned word write into the timer block this cycle
//   i_off        : word offset within the block (addr[3:2])
//   i_wd         : write data
//   o_rd         : read data for i_off (combinational)
//   o_irq        : match_flag & irq_en
module mmio_timer
  import soc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd,
  output logic        o_irq
);

  logic [31:0] r_count;
  logic [31:0] r_cmp;
  logic [2:0]  r_ctrl;
  logic        r_flag;

  logic w_cmp_wr, w_ctrl_wr, w_stat_wr;
  logic w_en, w_match;

  assign w_cmp_wr  = i_we && (i_off == OFF_CMP[3:2]);
  assign w_ctrl_wr = i_we && (i_off == OFF_CTRL[3:2]);
  assign w_stat_wr = i_we && (i_off == OFF_STATUS[3:2]);

  // A CTRL write that clears en stops the count at that very edge; a write
  // that sets en only starts counting from the following edge.
  assign w_en    = r_ctrl[CTRL_EN] && !(w_ctrl_wr && !i_wd[CTRL_EN]);
  // Compare uses the pre-edge CMP, so a CMP write affects the next edge.
  assign w_match = w_en && (r_count == r_cmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_cmp   <= '0;
      r_ctrl  <= '0;
      r_flag  <= 1'b0;
    end else begin
      if (w_cmp_wr)  r_cmp  <= i_wd;
      if (w_ctrl_wr) r_ctrl <= i_wd[2:0];
      if (w_en)      r_count <= (w_match && r_ctrl[CTRL_AUTO_RELOAD]) ? '0 : r_count + 32'd1;
      // Set wins over write-1-clear in the same cycle.
      if (w_match)                   r_flag <= 1'b1;
      else if (w_stat_wr && i_wd[0]) r_flag <= 1'b0;
    end
  end

  always_comb begin
    o_rd = '0;
    case (i_off)
      OFF_COUNT[3:2]:  o_rd = r_count;
      OFF_CMP[3:2]:    o_rd = r_cmp;
      OFF_CTRL[3:2]:   o_rd = {29'd0, r_ctrl};
      default:         o_rd = {31'd0, r_flag};
    endcase
  end

  assign o_irq = r_flag && r_ctrl[CTRL_IRQ_EN];

endmodule

// File: rtl/dmem_mmio.sv
// dmem_mmio: data-side memory unit for the single-cycle core.
//   Word-organised RAM with byte/half lane steering, little-endian, plus an
//   optional memory-mapped timer (present only when DMEM_TIMER_EN is defined;
//   otherwise the MMIO window decodes as unmapped and irq is tied low).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   mem_addr      : byte address
//   mem_wd        : store data, right-aligned for byte/half
//   mem_we        : store enable
//   mem_size      : 00 word, 01 half, 10 byte, 11 word
//   mem_rd        : load data, combinational, sign-extended for byte/half
//   irq           : timer interrupt level
//   bus_err       : registered pulse after an unmapped access
//   misalign_err  : registered pulse after a misaligned access
module dmem_mmio
  import soc_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
)(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wd,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  output logic [31:0] mem_rd,
  output logic        irq,
  output logic        bus_err,
  output logic        misalign_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  // RAM contents are deliberately not reset.
  logic [31:0] r_mem [DEPTH_WORDS];
  logic        r_bus_err, r_misalign;

  logic          w_is_half, w_is_byte, w_is_word;
  logic          w_misalign, w_ram_hit, w_mmio_hit, w_unmapped;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_word, w_ram_rd, w_wdata, w_tmr_rd;
  logic [3:0]    w_be;
  logic [31:0]   w_shift;

  assign w_is_half = (mem_size == SIZE_HALF);
  assign w_is_byte = (mem_size == SIZE_BYTE);
  assign w_is_word = !w_is_half && !w_is_byte;

  assign w_misalign = (w_is_half && mem_addr[0]) || (w_is_word && (mem_addr[1:0] != 2'b00));
  assign w_ram_hit  = {1'b0, mem_addr} < RAM_BYTES;
  assign w_idx      = mem_addr[AW+1:2];
  assign w_word     = r_mem[w_idx];

`ifdef DMEM_TIMER_EN
  logic w_tmr_irq;

  // Sub-word accesses to the timer window are treated as unmapped.
  assign w_mmio_hit = (mem_addr[31:4] == MMIO_BASE[31:4]) && w_is_word;

  mmio_timer u_timer (
    .clk   (clk),
    .rst   (rst),
    .i_we  (mem_we && w_mmio_hit && !w_misalign),
    .i_off (mem_addr[3:2]),
    .i_wd  (mem_wd),
    .o_rd  (w_tmr_rd),
    .o_irq (w_tmr_irq)
  );

  assign irq = w_tmr_irq;
`else
  assign w_mmio_hit = 1'b0;
  assign w_tmr_rd   = '0;
  assign irq        = 1'b0;
`endif

  assign w_unmapped = !w_ram_hit && !w_mmio_hit;

  // Store lane steering: replicate right-aligned data across lanes and let
  // the byte enables pick the addressed ones.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = mem_wd;
    if (w_is_byte) begin
      w_wdata = {4{mem_wd[7:0]}};
    end else if (w_is_half) begin
      w_wdata = {2{mem_wd[15:0]}};
    end
    if (mem_we && w_ram_hit && !w_misalign) begin
      if (w_is_byte)      w_be[mem_addr[1:0]] = 1'b1;
      else if (w_is_half) w_be = mem_addr[1] ? 4'b1100 : 4'b0011;
      else                w_be = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wdata[8*l +: 8];
    end
  end

  // Load lane extraction.
  assign w_shift = w_word >> {mem_addr[1:0], 3'b000};

  always_comb begin
    w_ram_rd = w_word;
    if (w_is_byte)      w_ram_rd = sext8(w_shift[7:0]);
    else if (w_is_half) w_ram_rd = sext16(w_shift[15:0]);
  end

  always_comb begin
    mem_rd = '0;
    if (!w_misalign) begin
      if (w_ram_hit)       mem_rd = w_ram_rd;
      else if (w_mmio_hit) mem_rd = w_tmr_rd;
    end
  end

  // Misalignment outranks the unmapped error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_err  <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_bus_err  <= w_unmapped && !w_misalign;
      r_misalign <= w_misalign;
    end
  end

  assign bus_err      = r_bus_err;
  assign misalign_err = r_misalign;

endmodule

// File: tb/tb_dmem_mmio.sv
module tb_dmem_mmio;
  import soc_pkg::*;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic        mem_we, irq, bus_err, misalign_err;
  logic [1:0]  mem_size;

  always #5 clk = ~clk;

  dmem_mmio #(.DEPTH_WORDS(1024), .MMIO_BASE(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_size     (mem_size),
    .mem_rd       (mem_rd),
    .irq          (irq),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  typedef enum int {S_RD, S_IRQ, S_BUS, S_MIS} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_tgl = 1'b0;

  // Monitor: drains the scoreboard at each negedge, or on demand for
  // checks that must happen without an intervening clock edge.
  always @(negedge clk or chk_tgl) begin
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sig)
        S_RD:    act = mem_rd;
        S_IRQ:   act = {31'd0, irq};
        S_BUS:   act = {31'd0, bus_err};
        default: act = {31'd0, misalign_err};
      endcase
      n_tests++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string n, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [1:0] sz);
    @(posedge clk);
    #1;
    mem_addr = a; mem_wd = d; mem_we = we; mem_size = sz;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] sz);
    drive(a, 32'd0, 1'b0, sz);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_addr = '0; mem_wd = '0; mem_we = 1'b0; mem_size = SIZE_WORD;
    @(posedge clk); #1;
    expect_v("reset_irq", S_IRQ, 0);
    expect_v("reset_bus", S_BUS, 0);
    expect_v("reset_mis", S_MIS, 0);
    @(negedge clk);
    rst = 1'b0;

    // Word round trip.
    drive(32'h10, 32'h1122_3344, 1'b1, SIZE_WORD);
    rd(32'h10, SIZE_WORD);            expect_v("word_rt", S_RD, 32'h1122_3344);

    // Byte store and sub-word loads.
    drive(32'h11, 32'h0000_00AB, 1'b1, SIZE_BYTE);
    rd(32'h10, SIZE_WORD);            expect_v("byte_st_word", S_RD, 32'h1122_AB44);
    rd(32'h11, SIZE_BYTE);            expect_v("byte_ld_11",   S_RD, 32'hFFFF_FFAB);
    rd(32'h12, SIZE_HALF);            expect_v("half_ld_12",   S_RD, 32'h0000_1122);
    rd(32'h10, SIZE_HALF);            expect_v("half_ld_10",   S_RD, 32'hFFFF_AB44);
    rd(32'h13, SIZE_BYTE);            expect_v("byte_ld_13",   S_RD, 32'h0000_0011);

    // Read-during-write shows pre-edge contents.
    drive(32'h10, 32'hDEAD_BEEF, 1'b1, SIZE_WORD);
    expect_v("rdw_old", S_RD, 32'h1122_AB44);
    rd(32'h10, SIZE_WORD);            expect_v("rdw_new", S_RD, 32'hDEAD_BEEF);

    // Half store uses only mem_wd[15:0].
    drive(32'h12, 32'hFFFF_CAFE, 1'b1, SIZE_HALF);
    rd(32'h10, SIZE_WORD);            expect_v("half_st_word", S_RD, 32'hCAFE_BEEF);
    rd(32'h12, SIZE_HALF);            expect_v("half_ld_neg",  S_RD, 32'hFFFF_CAFE);

    // Misaligned half store.
    drive(32'h14, 32'h5566_7788, 1'b1, SIZE_WORD);
    drive(32'h15, 32'h0000_FFFF, 1'b1, SIZE_HALF);
    expect_v("mis_rd0", S_RD, 0);
    expect_v("mis_pre", S_MIS, 0);
    rd(32'h14, SIZE_WORD);
    expect_v("mis_ram_kept", S_RD, 32'h5566_7788);
    expect_v("mis_pulse", S_MIS, 1);
    expect_v("mis_no_bus", S_BUS, 0);
    rd(32'h16, SIZE_WORD);
    expect_v("mis_one_cyc", S_MIS, 0);
    expect_v("mis_word_rd0", S_RD, 0);
    rd(32'h14, SIZE_WORD);
    expect_v("mis_word_pulse", S_MIS, 1);

    // Unmapped, back-to-back, and misaligned+unmapped priority.
    rd(32'h8000_0000, SIZE_WORD);     expect_v("unm_rd0", S_RD, 0);
    rd(32'h8000_0004, SIZE_WORD);     expect_v("unm_pulse", S_BUS, 1);
    rd(32'h10, SIZE_WORD);            expect_v("unm_b2b", S_BUS, 1);
    rd(32'h10, SIZE_WORD);            expect_v("unm_clear", S_BUS, 0);
    drive(32'h8000_0000, 32'h1, 1'b1, SIZE_WORD);
    rd(32'h8000_0001, SIZE_WORD);
    rd(32'h10, SIZE_WORD);
    expect_v("prio_mis", S_MIS, 1);
    expect_v("prio_bus", S_BUS, 0);

`ifdef DMEM_TIMER_EN
    // Sub-word MMIO access is unmapped.
    rd(MB, SIZE_HALF);                expect_v("mmio_half_rd0", S_RD, 0);
    rd(32'h10, SIZE_WORD);            expect_v("mmio_half_bus", S_BUS, 1);

    // Timer with auto-reload: CMP=3, CTRL=7 committed at E0.
    drive(MB + 32'h4, 32'd3, 1'b1, SIZE_WORD);
    drive(MB + 32'h8, 32'd7, 1'b1, SIZE_WORD);
    rd(MB, SIZE_WORD);                expect_v("cnt_e0", S_RD, 0);
    rd(MB, SIZE_WORD);                expect_v("cnt_e1", S_RD, 1);
    rd(MB, SIZE_WORD);                expect_v("cnt_e2", S_RD, 2);
    rd(MB, SIZE_WORD);
    expect_v("cnt_e3", S_RD, 3);
    expect_v("irq_e3", S_IRQ, 0);
    rd(MB, SIZE_WORD);
    expect_v("cnt_e4_reload", S_RD, 0);
    expect_v("irq_e4", S_IRQ, 1);
    rd(MB + 32'hC, SIZE_WORD);        expect_v("status_set", S_RD, 1);
    drive(MB + 32'hC, 32'd1, 1'b1, SIZE_WORD);
    expect_v("irq_before_clr", S_IRQ, 1);
    rd(MB + 32'hC, SIZE_WORD);
    expect_v("status_clr", S_RD, 0);
    expect_v("irq_clr", S_IRQ, 0);
    // E8 matches again; COUNT reloads, then counts to 1 after E9.
    rd(32'h8000_0000, SIZE_WORD);     expect_v("pre_rst_unm", S_RD, 0);
    rd(MB, SIZE_WORD);
    expect_v("pre_rst_cnt", S_RD, 1);
    expect_v("pre_rst_irq", S_IRQ, 1);
    expect_v("pre_rst_bus", S_BUS, 1);
`else
    rd(MB, SIZE_WORD);                expect_v("mmio_off_rd0", S_RD, 0);
    rd(32'h10, SIZE_WORD);
    expect_v("mmio_off_bus", S_BUS, 1);
    expect_v("pre_rst_ram", S_RD, 32'hCAFE_BEEF);
`endif

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    expect_v("arst_irq", S_IRQ, 0);
    expect_v("arst_bus", S_BUS, 0);
    expect_v("arst_mis", S_MIS, 0);
`ifdef DMEM_TIMER_EN
    expect_v("arst_cnt", S_RD, 0);
    chk_tgl = ~chk_tgl;
    #1 mem_addr = MB + 32'h8;
    #1 expect_v("arst_ctrl", S_RD, 0);
`endif
    chk_tgl = ~chk_tgl;
    #1 mem_addr = 32'h10;
    #1 expect_v("arst_ram_kept", S_RD, 32'hCAFE_BEEF);
    chk_tgl = ~chk_tgl;
    @(negedge clk);
    rst = 1'b0;
    rd(32'h10, SIZE_WORD);
    expect_v("post_rst_ram", S_RD, 32'hCAFE_BEEF);
    expect_v("post_rst_irq", S_IRQ, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
